// File: rtl/mini_src_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mini_src_pkg
// Purpose  : Shared definitions for the mini SRC control unit: opcode
//            constants, ALU ADD code, FSM state encoding and opcode classes.
// Revision : 1.0 - initial release
// ============================================================================
package mini_src_pkg;

    // Opcodes (IR[31:27])
    localparam logic [4:0] c_OP_LD       = 5'b00000;
    localparam logic [4:0] c_OP_LDI      = 5'b00001;
    localparam logic [4:0] c_OP_ST       = 5'b00010;
    localparam logic [4:0] c_OP_RCLS_0   = 5'b00011;  // add
    localparam logic [4:0] c_OP_RCLS_1   = 5'b00100;
    localparam logic [4:0] c_OP_RCLS_2   = 5'b00101;
    localparam logic [4:0] c_OP_RCLS_3   = 5'b00110;  // or
    localparam logic [4:0] c_OP_ADDI     = 5'b01100;
    localparam logic [4:0] c_OP_ANDI     = 5'b01101;
    localparam logic [4:0] c_OP_ORI      = 5'b01110;
    localparam logic [4:0] c_OP_BR       = 5'b10010;
    localparam logic [4:0] c_OP_JR       = 5'b10011;
    localparam logic [4:0] c_OP_NOP      = 5'b11010;
    localparam logic [4:0] c_OP_HALT     = 5'b11011;

    // ALU codes
    localparam logic [4:0] c_ALU_ADD     = 5'b00011;
    localparam logic [4:0] c_ALU_NONE    = 5'b00000;

    typedef enum logic [3:0] {
        ST_RST  = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_T6   = 4'd7,
        ST_T7   = 4'd8,
        ST_HALT = 4'd9
    } state_t;

    // HALT class covers both the halt opcode and every undefined opcode
    typedef enum logic [3:0] {
        CLS_R    = 4'd0,
        CLS_IMM  = 4'd1,
        CLS_LDI  = 4'd2,
        CLS_LD   = 4'd3,
        CLS_ST   = 4'd4,
        CLS_BR   = 4'd5,
        CLS_JR   = 4'd6,
        CLS_NOP  = 4'd7,
        CLS_HALT = 4'd8
    } opclass_t;

endpackage
`default_nettype wire

// File: rtl/mini_src_opclass_decode.sv
`default_nettype none
// ============================================================================
// Module   : mini_src_opclass_decode
// Purpose  : Combinational opcode -> instruction class decoder.
// Ports    : opcode   in  [4:0] IR[31:27]
//            op_class out       instruction class (undefined -> CLS_HALT)
// Revision : 1.0 - initial release
// ============================================================================
module mini_src_opclass_decode
    import mini_src_pkg::*;
(
    input  logic [4:0] opcode,
    output opclass_t   op_class
);

    always_comb begin
        op_class = CLS_HALT;
        case (opcode)
            c_OP_RCLS_0, c_OP_RCLS_1,
            c_OP_RCLS_2, c_OP_RCLS_3:      op_class = CLS_R;
            c_OP_ADDI, c_OP_ANDI, c_OP_ORI: op_class = CLS_IMM;
            c_OP_LDI:                      op_class = CLS_LDI;
            c_OP_LD:                       op_class = CLS_LD;
            c_OP_ST:                       op_class = CLS_ST;
            c_OP_BR:                       op_class = CLS_BR;
            c_OP_JR:                       op_class = CLS_JR;
            c_OP_NOP:                      op_class = CLS_NOP;
            default:                       op_class = CLS_HALT;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mini_src_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : mini_src_control_unit
// Purpose  : Hardwired control unit for the mini SRC datapath. A single
//            state register (RST, T0..T7, HALT) sequences fetch and execute;
//            all strobes are decoded from that state plus the opcode.
// Ports    : clock, clear(async, active-low), opcode[4:0], CON_FF,
//            mem_ready, stop -> datapath strobes, Read/Write, Run, alu_op[4:0]
// Revision : 1.0 - initial release
// ============================================================================
module mini_src_control_unit
    import mini_src_pkg::*;
(
    input  logic       clock,
    input  logic       clear,
    input  logic [4:0] opcode,
    input  logic       CON_FF,
    input  logic       mem_ready,
    input  logic       stop,
    output logic       Gra,
    output logic       Grb,
    output logic       Grc,
    output logic       Rin,
    output logic       Rout,
    output logic       BAout,
    output logic       Cout,
    output logic       PCout,
    output logic       PCin,
    output logic       IncPC,
    output logic       MARin,
    output logic       MDRin,
    output logic       MDRout,
    output logic       IRin,
    output logic       Yin,
    output logic       Zin,
    output logic       Zlowout,
    output logic       CONin,
    output logic       Read,
    output logic       Write,
    output logic       Run,
    output logic [4:0] alu_op
);

    state_t   r_state;
    opclass_t w_class;
    state_t   w_fetch_next;

    mini_src_opclass_decode u_decode (
        .opcode   (opcode),
        .op_class (w_class)
    );

    // Every instruction end goes through here so stop is honoured uniformly
    assign w_fetch_next = stop ? ST_HALT : ST_T0;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state <= ST_RST;
        end else begin
            case (r_state)
                ST_RST:  r_state <= ST_T0;
                ST_T0:   r_state <= ST_T1;
                ST_T1:   r_state <= mem_ready ? ST_T2 : ST_T1;
                ST_T2:   r_state <= ST_T3;
                ST_T3: begin
                    case (w_class)
                        CLS_R, CLS_IMM, CLS_LDI,
                        CLS_LD, CLS_ST, CLS_BR: r_state <= ST_T4;
                        CLS_JR, CLS_NOP:        r_state <= w_fetch_next;
                        default:                r_state <= ST_HALT;
                    endcase
                end
                ST_T4:   r_state <= ST_T5;
                ST_T5: begin
                    case (w_class)
                        CLS_LD, CLS_ST, CLS_BR: r_state <= ST_T6;
                        default:                r_state <= w_fetch_next;
                    endcase
                end
                ST_T6: begin
                    case (w_class)
                        CLS_LD:  r_state <= mem_ready ? ST_T7 : ST_T6;
                        CLS_ST:  r_state <= ST_T7;
                        default: r_state <= w_fetch_next;
                    endcase
                end
                ST_T7: begin
                    if (w_class == CLS_ST && !mem_ready) r_state <= ST_T7;
                    else                                 r_state <= w_fetch_next;
                end
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_RST;
            endcase
        end
    end

    always_comb begin
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
        BAout = 1'b0; Cout = 1'b0; PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0;
        MARin = 1'b0; MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0; Yin = 1'b0;
        Zin = 1'b0; Zlowout = 1'b0; CONin = 1'b0; Read = 1'b0; Write = 1'b0;
        alu_op = c_ALU_NONE;
        Run = (r_state != ST_RST) && (r_state != ST_HALT);
        case (r_state)
            ST_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
            ST_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            ST_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            ST_T3: begin
                case (w_class)
                    CLS_R, CLS_IMM:         begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    CLS_LDI, CLS_LD, CLS_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                    CLS_BR:                 begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                    CLS_JR:                 begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                    default: ;
                endcase
            end
            ST_T4: begin
                case (w_class)
                    CLS_R:   begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opcode; end
                    CLS_IMM: begin Cout = 1'b1; Zin = 1'b1; alu_op = opcode; end
                    CLS_LDI, CLS_LD, CLS_ST:
                             begin Cout = 1'b1; Zin = 1'b1; alu_op = c_ALU_ADD; end
                    CLS_BR:  begin PCout = 1'b1; Yin = 1'b1; end
                    default: ;
                endcase
            end
            ST_T5: begin
                case (w_class)
                    CLS_R, CLS_IMM, CLS_LDI: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    CLS_LD, CLS_ST:          begin Zlowout = 1'b1; MARin = 1'b1; end
                    CLS_BR:                  begin Cout = 1'b1; Zin = 1'b1; alu_op = c_ALU_ADD; end
                    default: ;
                endcase
            end
            ST_T6: begin
                case (w_class)
                    CLS_LD:  begin Read = 1'b1; MDRin = 1'b1; end
                    CLS_ST:  begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
                    // Branch taken only when the condition flag is set
                    CLS_BR:  begin Zlowout = 1'b1; PCin = CON_FF; end
                    default: ;
                endcase
            end
            ST_T7: begin
                case (w_class)
                    CLS_LD:  begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    CLS_ST:  Write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mini_src_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mini_src_control_unit
// Purpose  : Self-checking bench for mini_src_control_unit. Each cycle the
//            driver applies inputs and queues the expected strobe vector;
//            a monitor pops and compares it on the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mini_src_control_unit;

    // Observed/expected vector layout: {Gra..Run, alu_op[4:0]}
    localparam logic [25:0] M_GRA   = 26'd1 << 25;
    localparam logic [25:0] M_GRB   = 26'd1 << 24;
    localparam logic [25:0] M_GRC   = 26'd1 << 23;
    localparam logic [25:0] M_RIN   = 26'd1 << 22;
    localparam logic [25:0] M_ROUT  = 26'd1 << 21;
    localparam logic [25:0] M_BAOUT = 26'd1 << 20;
    localparam logic [25:0] M_COUT  = 26'd1 << 19;
    localparam logic [25:0] M_PCOUT = 26'd1 << 18;
    localparam logic [25:0] M_PCIN  = 26'd1 << 17;
    localparam logic [25:0] M_INCPC = 26'd1 << 16;
    localparam logic [25:0] M_MARIN = 26'd1 << 15;
    localparam logic [25:0] M_MDRIN = 26'd1 << 14;
    localparam logic [25:0] M_MDROU = 26'd1 << 13;
    localparam logic [25:0] M_IRIN  = 26'd1 << 12;
    localparam logic [25:0] M_YIN   = 26'd1 << 11;
    localparam logic [25:0] M_ZIN   = 26'd1 << 10;
    localparam logic [25:0] M_ZLOW  = 26'd1 << 9;
    localparam logic [25:0] M_CONIN = 26'd1 << 8;
    localparam logic [25:0] M_READ  = 26'd1 << 7;
    localparam logic [25:0] M_WRITE = 26'd1 << 6;
    localparam logic [25:0] M_RUN   = 26'd1 << 5;
    localparam logic [25:0] M_ADD   = 26'd3;

    localparam logic [25:0] c_T0V = M_PCOUT | M_MARIN | M_INCPC | M_ZIN | M_RUN;
    localparam logic [25:0] c_T1V = M_ZLOW | M_PCIN | M_READ | M_MDRIN | M_RUN;
    localparam logic [25:0] c_T2V = M_MDROU | M_IRIN | M_RUN;

    typedef struct {
        string       tag;
        logic [25:0] v;
    } exp_t;

    logic       r_clk = 1'b0;
    logic       r_clear = 1'b0;
    logic [4:0] r_opcode = 5'b0;
    logic       r_con = 1'b0;
    logic       r_mem_ready = 1'b0;
    logic       r_stop = 1'b0;

    logic w_gra, w_grb, w_grc, w_rin, w_rout, w_baout, w_cout, w_pcout, w_pcin;
    logic w_incpc, w_marin, w_mdrin, w_mdrout, w_irin, w_yin, w_zin, w_zlow;
    logic w_conin, w_read, w_write, w_run;
    logic [4:0]  w_alu;
    logic [25:0] w_obs;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 r_clk = ~r_clk;

    mini_src_control_unit dut (
        .clock(r_clk), .clear(r_clear), .opcode(r_opcode), .CON_FF(r_con),
        .mem_ready(r_mem_ready), .stop(r_stop),
        .Gra(w_gra), .Grb(w_grb), .Grc(w_grc), .Rin(w_rin), .Rout(w_rout),
        .BAout(w_baout), .Cout(w_cout), .PCout(w_pcout), .PCin(w_pcin),
        .IncPC(w_incpc), .MARin(w_marin), .MDRin(w_mdrin), .MDRout(w_mdrout),
        .IRin(w_irin), .Yin(w_yin), .Zin(w_zin), .Zlowout(w_zlow),
        .CONin(w_conin), .Read(w_read), .Write(w_write), .Run(w_run),
        .alu_op(w_alu)
    );

    assign w_obs = {w_gra, w_grb, w_grc, w_rin, w_rout, w_baout, w_cout, w_pcout,
                    w_pcin, w_incpc, w_marin, w_mdrin, w_mdrout, w_irin, w_yin,
                    w_zin, w_zlow, w_conin, w_read, w_write, w_run, w_alu};

    task automatic check(input string tag, input logic [25:0] obs, input logic [25:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Scoreboard consumer
    always @(negedge r_clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check(e.tag, w_obs, e.v);
            check({e.tag, "_rw_excl"}, 26'(w_read & w_write), 26'd0);
            check({e.tag, "_rinout_excl"}, 26'(w_rin & w_rout), 26'd0);
        end
    end

    // One clock cycle: apply inputs shortly after the edge, queue expectation
    task automatic cyc(input string tag, input logic [25:0] e, input logic [4:0] op,
                       input logic con, input logic mr, input logic stp, input logic clr);
        exp_t x;
        @(posedge r_clk);
        #2;
        r_opcode = op; r_con = con; r_mem_ready = mr; r_stop = stp; r_clear = clr;
        x.tag = tag; x.v = e;
        exp_q.push_back(x);
    endtask

    // Full instruction from T0; fw/mw = not-ready cycles in fetch/memory wait
    task automatic run_instr(input logic [4:0] op, input logic con, input int fw,
                             input int mw, input logic stp);
        logic [25:0] a;
        a = {21'd0, op};
        cyc("T0", c_T0V, op, con, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < fw; i++) cyc("T1_wait", c_T1V, op, con, 1'b0, 1'b0, 1'b1);
        cyc("T1", c_T1V, op, con, 1'b1, 1'b0, 1'b1);
        cyc("T2", c_T2V, op, con, 1'b0, 1'b0, 1'b1);
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
                cyc("R_T3", M_GRB | M_ROUT | M_YIN | M_RUN, op, con, 1'b0, 1'b0, 1'b1);
                cyc("R_T4", M_GRC | M_ROUT | M_ZIN | M_RUN | a, op, con, 1'b1, 1'b0, 1'b1);
                cyc("R_T5", M_ZLOW | M_GRA | M_RIN | M_RUN, op, con, 1'b1, stp, 1'b1);
            end
            5'b01100, 5'b01101, 5'b01110: begin
                cyc("I_T3", M_GRB | M_ROUT | M_YIN | M_RUN, op, con, 1'b1, 1'b0, 1'b1);
                cyc("I_T4", M_COUT | M_ZIN | M_RUN | a, op, con, 1'b0, 1'b0, 1'b1);
                cyc("I_T5", M_ZLOW | M_GRA | M_RIN | M_RUN, op, con, 1'b1, stp, 1'b1);
            end
            5'b00001, 5'b00000, 5'b00010: begin
                cyc("A_T3", M_GRB | M_BAOUT | M_YIN | M_RUN, op, con, 1'b1, 1'b0, 1'b1);
                cyc("A_T4", M_COUT | M_ZIN | M_RUN | M_ADD, op, con, 1'b1, 1'b0, 1'b1);
                if (op == 5'b00001) begin
                    cyc("LDI_T5", M_ZLOW | M_GRA | M_RIN | M_RUN, op, con, 1'b1, stp, 1'b1);
                end else begin
                    cyc("M_T5", M_ZLOW | M_MARIN | M_RUN, op, con, 1'b0, 1'b0, 1'b1);
                    if (op == 5'b00000) begin
                        for (int i = 0; i < mw; i++)
                            cyc("LD_T6_wait", M_READ | M_MDRIN | M_RUN, op, con, 1'b0, 1'b0, 1'b1);
                        cyc("LD_T6", M_READ | M_MDRIN | M_RUN, op, con, 1'b1, 1'b0, 1'b1);
                        cyc("LD_T7", M_MDROU | M_GRA | M_RIN | M_RUN, op, con, 1'b0, stp, 1'b1);
                    end else begin
                        cyc("ST_T6", M_GRA | M_ROUT | M_MDRIN | M_RUN, op, con, 1'b0, 1'b0, 1'b1);
                        for (int i = 0; i < mw; i++)
                            cyc("ST_T7_wait", M_WRITE | M_RUN, op, con, 1'b0, 1'b0, 1'b1);
                        cyc("ST_T7", M_WRITE | M_RUN, op, con, 1'b1, stp, 1'b1);
                    end
                end
            end
            5'b10010: begin
                cyc("BR_T3", M_GRA | M_ROUT | M_CONIN | M_RUN, op, con, 1'b1, 1'b0, 1'b1);
                cyc("BR_T4", M_PCOUT | M_YIN | M_RUN, op, con, 1'b1, 1'b0, 1'b1);
                cyc("BR_T5", M_COUT | M_ZIN | M_RUN | M_ADD, op, con, 1'b0, 1'b0, 1'b1);
                cyc("BR_T6", M_ZLOW | (con ? M_PCIN : 26'd0) | M_RUN, op, con, 1'b0, stp, 1'b1);
            end
            5'b10011: cyc("JR_T3", M_GRA | M_ROUT | M_PCIN | M_RUN, op, con, 1'b1, stp, 1'b1);
            5'b11010: cyc("NOP_T3", M_RUN, op, con, 1'b1, stp, 1'b1);
            default:  cyc("HLT_T3", M_RUN, op, con, 1'b1, 1'b0, 1'b1);
        endcase
    endtask

    task automatic hold_halt(input logic [4:0] op, input int n);
        for (int i = 0; i < n; i++)
            cyc("HALT", 26'd0, op, i[0], i[1], i[2], 1'b1);
    endtask

    // Clear pulse: outputs drop in the asserted cycle, RST in the release cycle
    task automatic do_clear(input logic [4:0] op);
        cyc("CLR_low", 26'd0, op, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("CLR_rel", 26'd0, op, 1'b0, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) cyc("reset", 26'd0, 5'b00011, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("RST", 26'd0, 5'b00011, 1'b0, 1'b1, 1'b0, 1'b1);

        run_instr(5'b00011, 1'b0, 0, 0, 1'b0);   // add
        run_instr(5'b00100, 1'b0, 2, 0, 1'b0);   // R-class with fetch wait
        run_instr(5'b00101, 1'b0, 0, 0, 1'b0);
        run_instr(5'b01100, 1'b0, 0, 0, 1'b0);   // addi
        run_instr(5'b01101, 1'b0, 1, 0, 1'b0);   // andi
        run_instr(5'b01110, 1'b0, 0, 0, 1'b0);   // ori
        run_instr(5'b00001, 1'b0, 0, 0, 1'b0);   // ldi
        run_instr(5'b00000, 1'b0, 0, 3, 1'b0);   // ld, 3-cycle memory wait
        run_instr(5'b00000, 1'b0, 0, 0, 1'b0);
        run_instr(5'b00010, 1'b0, 0, 2, 1'b0);   // st, 2-cycle write wait
        run_instr(5'b10010, 1'b0, 0, 0, 1'b0);   // br not taken
        run_instr(5'b10010, 1'b1, 0, 0, 1'b0);   // br taken
        run_instr(5'b10011, 1'b0, 0, 0, 1'b0);   // jr
        run_instr(5'b11010, 1'b0, 0, 0, 1'b0);   // nop

        // clear during fetch memory wait
        cyc("T0", c_T0V, 5'b00011, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("T1_wait", c_T1V, 5'b00011, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("T1_wait", c_T1V, 5'b00011, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("CLR_in_T1", 26'd0, 5'b00011, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("CLR_rel", 26'd0, 5'b00011, 1'b0, 1'b0, 1'b0, 1'b1);
        run_instr(5'b00011, 1'b0, 0, 0, 1'b0);

        // halt opcode
        run_instr(5'b11011, 1'b0, 0, 0, 1'b0);
        hold_halt(5'b11011, 20);
        do_clear(5'b11011);

        // illegal opcode
        run_instr(5'b11111, 1'b0, 0, 0, 1'b0);
        hold_halt(5'b11111, 3);
        do_clear(5'b11111);

        // stop during R-class T5
        run_instr(5'b00110, 1'b0, 0, 0, 1'b1);
        hold_halt(5'b00110, 3);
        do_clear(5'b00110);

        // stop at the end of a store
        run_instr(5'b00010, 1'b0, 0, 1, 1'b1);
        hold_halt(5'b00010, 2);
        do_clear(5'b00010);

        run_instr(5'b00011, 1'b0, 0, 0, 1'b0);

        @(negedge r_clk);
        #1;
        check("scoreboard_drain", 26'(exp_q.size()), 26'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
